// File: rtl/sweep_count_ctrl.sv
// sweep_count_ctrl
//   Sweep controller wrapping an 8-bit up/down counter. A command (start,
//   end, reversal count) is accepted over a valid/ready handshake. The
//   counter then runs start->end, optionally bouncing between the two
//   endpoints cmd_legs more times (triangle wave), and finally pulses done.
//   RUN can be frozen with pause or abandoned with abort.
//
// Ports
//   clk, reset              clock; synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake (ready only in IDLE)
//   cmd_start, cmd_end      first count value and first target value
//   cmd_legs                reversals after the first sweep (0 = one sweep)
//   pause, abort            freeze / abandon while running
//   count, dir              registered counter value and direction (1 = up)
//   busy                    controller not idle
//   done                    high for the single DONE cycle
//   aborted                 registered pulse the cycle after an abort
module sweep_count_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_start,
    input  logic [WIDTH-1:0] cmd_end,
    input  logic [3:0]       cmd_legs,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             aborted
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state, state_n;
    logic [WIDTH-1:0] target, target_n;
    logic [WIDTH-1:0] other, other_n;
    logic [WIDTH-1:0] count_n;
    logic [3:0]       legs_left, legs_n;
    logic             dir_n;
    logic             aborted_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            dir       <= 1'b1;
            target    <= '0;
            other     <= '0;
            legs_left <= '0;
            aborted   <= 1'b0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            dir       <= dir_n;
            target    <= target_n;
            other     <= other_n;
            legs_left <= legs_n;
            aborted   <= aborted_n;
        end
    end

    always_comb begin
        state_n   = state;
        count_n   = count;
        dir_n     = dir;
        target_n  = target;
        other_n   = other;
        legs_n    = legs_left;
        aborted_n = 1'b0;

        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    count_n  = cmd_start;
                    target_n = cmd_end;
                    other_n  = cmd_start;
                    legs_n   = cmd_legs;
                    dir_n    = (cmd_end >= cmd_start);
                    state_n  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n   = IDLE;
                    aborted_n = 1'b1;
                end else if (pause) begin
                    state_n = RUN;
                end else if (count != target) begin
                    count_n = dir ? count + ONE : count - ONE;
                // target==other only when start==end: a zero-length sweep
                // finishes immediately instead of bouncing in place.
                end else if (legs_left == 4'd0 || target == other) begin
                    state_n = DONE;
                end else begin
                    // Reversal: swap endpoints, flip direction and take the
                    // first step toward the new target on this same edge so
                    // each endpoint is shown for exactly one cycle.
                    target_n = other;
                    other_n  = target;
                    dir_n    = ~dir;
                    legs_n   = legs_left - 4'd1;
                    count_n  = dir ? count - ONE : count + ONE;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);

endmodule

// File: tb/tb_sweep_count_ctrl.sv
// tb_sweep_count_ctrl
//   Self-checking bench for sweep_count_ctrl. Each command's expected
//   per-cycle outputs are derived arithmetically from (start, end, legs)
//   and queued when the command is driven; one entry is popped and compared
//   per cycle. Pause/abort, mid-sweep reset and reset values are checked by
//   hand-written sequences.
module tb_sweep_count_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_start;
    logic [7:0] cmd_end;
    logic [3:0] cmd_legs;
    logic       pause;
    logic       abort;
    logic [7:0] count;
    logic       dir;
    logic       busy;
    logic       done;
    logic       aborted;

    int vectors     = 0;
    int miscompares = 0;

    sweep_count_ctrl #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_start (cmd_start),
        .cmd_end   (cmd_end),
        .cmd_legs  (cmd_legs),
        .pause     (pause),
        .abort     (abort),
        .count     (count),
        .dir       (dir),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] count;
        logic       dir;
        logic       busy;
        logic       done;
        logic       ready;
        logic       aborted;
    } obs_t;

    typedef struct {
        logic [7:0] s;
        logic [7:0] e;
        logic [3:0] l;
        logic [7:0] fin;
    } vec_t;

    obs_t sb[$];

    function automatic obs_t observe();
        obs_t o;
        o.count   = count;
        o.dir     = dir;
        o.busy    = busy;
        o.done    = done;
        o.ready   = cmd_ready;
        o.aborted = aborted;
        return o;
    endfunction

    // Count value i edges after accept: leg k runs start->end when k is
    // even and end->start when k is odd.
    function automatic int exp_val(int s, int e, int n, int i);
        int k, r, sg;
        if (n == 0) return s;
        k  = i / n;
        r  = i % n;
        sg = (e >= s) ? 1 : -1;
        if (k % 2 == 0) return s + sg * r;
        return e - sg * r;
    endfunction

    // Direction i edges after accept: that of the leg whose step landed here.
    function automatic logic exp_dir(int s, int e, int n, int i);
        logic d0;
        d0 = (e >= s);
        if (i == 0 || n == 0) return d0;
        if (((i - 1) / n) % 2 == 0) return d0;
        return ~d0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one command at a negedge and compare every cycle from the
    // accept edge until the first IDLE cycle. With intrude set, a foreign
    // command is presented for several RUN cycles and must be ignored.
    task automatic run_cmd(input logic [7:0] s, input logic [7:0] e,
                           input logic [3:0] l, input bit intrude);
        int n, m, idx;
        obs_t ex, act;
        n = (e >= s) ? int'(e) - int'(s) : int'(s) - int'(e);
        m = n * (int'(l) + 1);
        chk("ready_before_cmd", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_start = s;
        cmd_end   = e;
        cmd_legs  = l;
        for (int i = 0; i <= m; i++) begin
            ex.count   = 8'(exp_val(s, e, n, i));
            ex.dir     = exp_dir(s, e, n, i);
            ex.busy    = 1'b1;
            ex.done    = 1'b0;
            ex.ready   = 1'b0;
            ex.aborted = 1'b0;
            sb.push_back(ex);
        end
        ex.count = 8'(exp_val(s, e, n, m));
        ex.dir   = exp_dir(s, e, n, m);
        ex.done  = 1'b1;
        sb.push_back(ex);
        ex.busy  = 1'b0;
        ex.done  = 1'b0;
        ex.ready = 1'b1;
        sb.push_back(ex);
        idx = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            if (intrude && idx >= 1 && idx <= 5) begin
                cmd_valid = 1'b1;
                cmd_start = 8'd200;
                cmd_end   = 8'd210;
                cmd_legs  = 4'd2;
            end else begin
                cmd_valid = 1'b0;
            end
            ex  = sb.pop_front();
            act = observe();
            vectors++;
            if (act !== ex) begin
                miscompares++;
                $display("FAIL sweep %0d->%0d legs %0d cyc %0d: got cnt=%0d dir=%0b busy=%0b done=%0b rdy=%0b ab=%0b expected cnt=%0d dir=%0b busy=%0b done=%0b rdy=%0b ab=%0b",
                         s, e, l, idx, act.count, act.dir, act.busy, act.done, act.ready, act.aborted,
                         ex.count, ex.dir, ex.busy, ex.done, ex.ready, ex.aborted);
            end
            idx++;
        end
        cmd_valid = 1'b0;
    endtask

    vec_t tbl[6];
    int   done_seen;
    int   wait_cnt;

    initial begin
        tbl[0] = '{s: 8'd3,   e: 8'd7,   l: 4'd0, fin: 8'd7};
        tbl[1] = '{s: 8'd10,  e: 8'd8,   l: 4'd3, fin: 8'd10};
        tbl[2] = '{s: 8'd250, e: 8'd2,   l: 4'd0, fin: 8'd2};
        tbl[3] = '{s: 8'd0,   e: 8'd255, l: 4'd0, fin: 8'd255};
        tbl[4] = '{s: 8'd5,   e: 8'd5,   l: 4'd4, fin: 8'd5};
        tbl[5] = '{s: 8'd20,  e: 8'd25,  l: 4'd2, fin: 8'd25};

        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_start = '0;
        cmd_end   = '0;
        cmd_legs  = '0;
        pause     = 1'b0;
        abort     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_count", {24'd0, count}, 32'd0);
        chk("reset_dir", {31'd0, dir}, 32'd1);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_aborted", {31'd0, aborted}, 32'd0);
        reset = 1'b0;

        // abort while idle must be ignored
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_aborted", {31'd0, aborted}, 32'd0);
        chk("idle_abort_ready", {31'd0, cmd_ready}, 32'd1);

        for (int t = 0; t < 6; t++) begin
            run_cmd(tbl[t].s, tbl[t].e, tbl[t].l, 1'b0);
            chk("final_count", {24'd0, count}, {24'd0, tbl[t].fin});
        end

        // pause two cycles at 3, then abort at 5
        done_seen = 0;
        cmd_valid = 1'b1;
        cmd_start = 8'd0;
        cmd_end   = 8'd6;
        cmd_legs  = 4'd0;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_cnt  = 0;
        while (count != 8'd3 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("reach_3", {31'd0, (wait_cnt < 20)}, 32'd1);
        pause = 1'b1;
        @(negedge clk);
        if (done) done_seen++;
        chk("pause_hold_1", {24'd0, count}, 32'd3);
        @(negedge clk);
        if (done) done_seen++;
        chk("pause_hold_2", {24'd0, count}, 32'd3);
        pause = 1'b0;
        @(negedge clk);
        if (done) done_seen++;
        chk("resume_4", {24'd0, count}, 32'd4);
        @(negedge clk);
        if (done) done_seen++;
        chk("resume_5", {24'd0, count}, 32'd5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        if (done) done_seen++;
        chk("abort_pulse", {31'd0, aborted}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
        chk("abort_count", {24'd0, count}, 32'd5);
        chk("abort_dir", {31'd0, dir}, 32'd1);
        @(negedge clk);
        if (done) done_seen++;
        chk("abort_pulse_end", {31'd0, aborted}, 32'd0);
        chk("abort_count_hold", {24'd0, count}, 32'd5);
        chk("abort_no_done", done_seen, 32'd0);

        // mid-sweep reset
        cmd_valid = 1'b1;
        cmd_start = 8'd120;
        cmd_end   = 8'd100;
        cmd_legs  = 4'd1;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_count", {24'd0, count}, 32'd117);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset_count", {24'd0, count}, 32'd0);
        chk("midreset_dir", {31'd0, dir}, 32'd1);
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_done", {31'd0, done}, 32'd0);
        chk("midreset_aborted", {31'd0, aborted}, 32'd0);

        // foreign commands offered during RUN are ignored
        run_cmd(8'd40, 8'd44, 4'd1, 1'b1);
        chk("intrude_final", {24'd0, count}, 32'd40);
        @(negedge clk);
        chk("intrude_idle", {31'd0, cmd_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
